// File: rtl/pwm_bank_pkg.sv
// Shared opcode/state enums and response constants for the PWM bank controller.
package pwm_bank_pkg;

   typedef enum logic [3:0] {
      OP_SET_DUTY  = 4'h0,
      OP_SET_EN    = 4'h1,
      OP_READ_DUTY = 4'h2,
      OP_ALL_OFF   = 4'h3
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   function automatic logic op_known(input logic [3:0] op);
      return (op <= 4'h3);
   endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Byte command/response handshake between a host and pwm_bank_ctrl.
interface pwm_bank_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;

   modport master (output rx_valid, output rx_data, output tx_ready,
                   input  tx_valid, input  tx_data);
   modport slave  (input  rx_valid, input  rx_data, input  tx_ready,
                   output tx_valid, output tx_data);
endinterface

// File: rtl/pwm_bank_core.sv
// Prescaler, shared period counter and per-channel compare with wrap-aligned duty update.
// Optional build macro PWM_BANK_FADE_EN: duty_act steps by 1 toward duty_tgt per period.
module pwm_bank_core #(
   parameter int NUM_CH    = 8,
   parameter int PWM_BITS  = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DIV_WIDTH-1:0]               div,
   input  logic [NUM_CH-1:0]                  en,
   input  logic [NUM_CH-1:0][PWM_BITS-1:0]    duty_tgt,
   output logic [NUM_CH-1:0]                  pwm_o
);

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PWM_BITS-1:0]  CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
   localparam logic [PWM_BITS-1:0]  CNT_MAX  = {PWM_BITS{1'b1}};

   logic [DIV_WIDTH-1:0]            pre_q, pre_d, div_last_s;
   logic [PWM_BITS-1:0]             cnt_q, cnt_d;
   logic [NUM_CH-1:0][PWM_BITS-1:0] duty_act_q, duty_act_d;
   logic [NUM_CH-1:0]               pwm_q, pwm_d;
   logic                            tick_s, wrap_s;

   // Next-state for prescaler, counter, active duty and compare outputs.
   always_comb begin
      // >= keeps the prescaler bounded if div shrinks below the running count
      div_last_s = (div == DIV_ZERO) ? DIV_ZERO : (div - DIV_ONE);
      tick_s     = (pre_q >= div_last_s);
      pre_d      = tick_s ? DIV_ZERO : (pre_q + DIV_ONE);
      cnt_d      = tick_s ? (cnt_q + CNT_ONE) : cnt_q;
      wrap_s     = tick_s && (cnt_q == CNT_MAX);
      duty_act_d = duty_act_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wrap_s) begin
`ifdef PWM_BANK_FADE_EN
            if (duty_act_q[c] < duty_tgt[c]) begin
               duty_act_d[c] = duty_act_q[c] + CNT_ONE;
            end else if (duty_act_q[c] > duty_tgt[c]) begin
               duty_act_d[c] = duty_act_q[c] - CNT_ONE;
            end else begin
               duty_act_d[c] = duty_act_q[c];
            end
`else
            duty_act_d[c] = duty_tgt[c];
`endif
         end else begin
            duty_act_d[c] = duty_act_q[c];
         end
         pwm_d[c] = en[c] && (cnt_q < duty_act_q[c]);
      end
   end

   // Core state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q      <= DIV_ZERO;
         cnt_q      <= {PWM_BITS{1'b0}};
         duty_act_q <= '{default: {PWM_BITS{1'b0}}};
         pwm_q      <= {NUM_CH{1'b0}};
      end else begin
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         duty_act_q <= duty_act_d;
         pwm_q      <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank_ctrl.sv
// PWM bank top: byte-command parser FSM owning en/duty_tgt, feeding pwm_bank_core.
// Build macro PWM_BANK_FADE_EN (see pwm_bank_core) selects fading duty updates.
module pwm_bank_ctrl
   import pwm_bank_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int PWM_BITS  = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] div,
   pwm_bank_if.slave            bus,
   output logic [NUM_CH-1:0]    pwm_o,
   output logic                 busy
);

   state_e                          state_q, state_d;
   logic [3:0]                      op_q, op_d, ch_q, ch_d;
   logic [NUM_CH-1:0]               en_q, en_d;
   logic [NUM_CH-1:0][PWM_BITS-1:0] duty_q, duty_d;
   logic                            tx_valid_q, tx_valid_d, busy_q, busy_d;
   logic [7:0]                      tx_data_q, tx_data_d, rd_byte_s;
   logic [3:0]                      hdr_op_s, hdr_ch_s;
   logic                            hdr_ok_s;
   logic [PWM_BITS-1:0]             arg_duty_s;

   // Parser next-state, register writes and response generation.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      ch_d       = ch_q;
      en_d       = en_q;
      duty_d     = duty_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      hdr_op_s   = bus.rx_data[7:4];
      hdr_ch_s   = bus.rx_data[3:0];
      hdr_ok_s   = op_known(hdr_op_s) && (int'(hdr_ch_s) < NUM_CH);
      arg_duty_s = PWM_BITS'(bus.rx_data);
      rd_byte_s  = 8'h00;
      for (int c = 0; c < NUM_CH; c++) begin
         rd_byte_s = rd_byte_s | ((4'(c) == hdr_ch_s) ? 8'(duty_q[c]) : 8'h00);
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid && !hdr_ok_s) begin
               tx_data_d  = RSP_NAK;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP;
            end else if (bus.rx_valid) begin
               op_d = hdr_op_s;
               ch_d = hdr_ch_s;
               case (hdr_op_s)
                  OP_SET_DUTY, OP_SET_EN: begin
                     state_d = ST_ARG;
                  end
                  OP_READ_DUTY: begin
                     tx_data_d  = rd_byte_s;
                     tx_valid_d = 1'b1;
                     state_d    = ST_RESP;
                  end
                  OP_ALL_OFF: begin
                     en_d       = {NUM_CH{1'b0}};
                     tx_data_d  = RSP_ACK;
                     tx_valid_d = 1'b1;
                     state_d    = ST_RESP;
                  end
                  default: begin
                     tx_data_d  = RSP_NAK;
                     tx_valid_d = 1'b1;
                     state_d    = ST_RESP;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARG: begin
            if (bus.rx_valid) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  duty_d[c] = ((4'(c) == ch_q) && (op_q == OP_SET_DUTY)) ? arg_duty_s : duty_q[c];
                  en_d[c]   = ((4'(c) == ch_q) && (op_q == OP_SET_EN)) ? bus.rx_data[0] : en_q[c];
               end
               tx_data_d  = RSP_ACK;
               tx_valid_d = 1'b1;
               state_d    = ST_RESP;
            end else begin
               state_d = ST_ARG;
            end
         end
         ST_RESP: begin
            if (tx_valid_q && bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Parser and register-file state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= 4'h0;
         ch_q       <= 4'h0;
         en_q       <= {NUM_CH{1'b0}};
         duty_q     <= '{default: {PWM_BITS{1'b0}}};
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ch_q       <= ch_d;
         en_q       <= en_d;
         duty_q     <= duty_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign busy         = busy_q;

   pwm_bank_core #(
      .NUM_CH   (NUM_CH),
      .PWM_BITS (PWM_BITS),
      .DIV_WIDTH(DIV_WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .div     (div),
      .en      (en_q),
      .duty_tgt(duty_q),
      .pwm_o   (pwm_o)
   );

endmodule
